// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_INSTR_W = 16;
    localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = 16'b0000000000000011;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard/branch controls in, IF/ID payload and imem port out.
interface fetch_unit_if #(
    parameter int ADDR_W  = fetch_pkg::DEF_ADDR_W,
    parameter int INSTR_W = fetch_pkg::DEF_INSTR_W
);
    logic               pc_write_i;
    logic               redirect_i;
    logic [ADDR_W-1:0]  redirect_pc_i;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic [ADDR_W-1:0]  pc_plus1_o;
    logic [INSTR_W-1:0] instr_o;
    logic               instr_valid_o;
    logic               flush_n_o;

    modport master (
        input  pc_write_i, redirect_i, redirect_pc_i, imem_rdata_i,
        output imem_addr_o, pc_plus1_o, instr_o, instr_valid_o, flush_n_o
    );

    modport slave (
        output pc_write_i, redirect_i, redirect_pc_i, imem_rdata_i,
        input  imem_addr_o, pc_plus1_o, instr_o, instr_valid_o, flush_n_o
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for the instruction presented when a stall begins.
module fetch_skid_buf #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load,
    input  logic               clear,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic               valid
);
    // Only the valid flag needs a reset; the payload is ignored while invalid.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, sync-memory response tracking, stall skid and redirect bubble.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W    = DEF_ADDR_W,
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = DEF_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_unit_if.master bus
);
    fetch_state_t       state_q, state_next;
    logic [ADDR_W-1:0]  pc_q, pc_next;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_next;
    logic               resp_valid_q, resp_valid_next;
    logic               skid_load, skid_clear;
    logic [ADDR_W-1:0]  skid_pc_q;
    logic [INSTR_W-1:0] skid_instr_q;
    logic               skid_valid_q;

    fetch_skid_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_pc    (resp_pc_q),
        .load_instr (bus.imem_rdata_i),
        .pc         (skid_pc_q),
        .instr      (skid_instr_q),
        .valid      (skid_valid_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= BUBBLE;
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_next;
            pc_q         <= pc_next;
            resp_pc_q    <= resp_pc_next;
            resp_valid_q <= resp_valid_next;
        end
    end

    // Redirect beats stall; a stall out of RUN parks the live memory word in the skid.
    always_comb begin
        state_next      = state_q;
        pc_next         = pc_q;
        resp_pc_next    = resp_pc_q;
        resp_valid_next = resp_valid_q;
        skid_load       = 1'b0;
        skid_clear      = 1'b0;
        if (bus.redirect_i) begin
            pc_next         = bus.redirect_pc_i;
            resp_valid_next = 1'b0;
            skid_clear      = 1'b1;
            state_next      = BUBBLE;
        end else if (bus.pc_write_i) begin
            pc_next         = pc_q + ADDR_W'(1);
            resp_pc_next    = pc_q;
            resp_valid_next = 1'b1;
            skid_clear      = 1'b1;
            state_next      = RUN;
        end else begin
            resp_valid_next = 1'b0;
            if (state_q == RUN) begin
                skid_load  = resp_valid_q;
                state_next = HOLD;
            end
        end
    end

    always_comb begin
        bus.instr_o       = NOP_INSTR;
        bus.pc_plus1_o    = pc_q;
        bus.instr_valid_o = 1'b0;
        case (state_q)
            RUN: begin
                bus.instr_o       = bus.imem_rdata_i;
                bus.pc_plus1_o    = resp_pc_q + ADDR_W'(1);
                bus.instr_valid_o = resp_valid_q;
            end
            HOLD: begin
                bus.instr_o       = skid_instr_q;
                bus.pc_plus1_o    = skid_pc_q + ADDR_W'(1);
                bus.instr_valid_o = skid_valid_q;
            end
            default: ;
        endcase
    end

    assign bus.imem_addr_o = pc_q;
    assign bus.flush_n_o   = ~bus.redirect_i;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table, hand-written corner steps and a random run against an abstract fetch model.
module tb_fetch_unit;
    localparam logic [15:0] NOP = 16'h0003;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {4'h1, a[11:0]};
    endfunction

    // Synchronous instruction memory: data for last cycle's address.
    always_ff @(posedge clk) bus.imem_rdata_i <= mem_word(bus.imem_addr_o);

    typedef struct {
        bit          rst;
        bit          pcw;
        bit          redir;
        logic [15:0] tgt;
        bit          chk;
        logic [15:0] instr;
        bit          valid;
        logic [15:0] pc1;
        logic [15:0] addr;
    } vec_t;

    vec_t tbl[30];

    // Abstract model: the stage shows the most recently fetched address, or a bubble.
    bit          m_known  = 0;
    bit          m_bubble = 1;
    logic [15:0] m_next   = 16'h0;
    logic [15:0] m_addr   = 16'h0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit w, input bit d, input logic [15:0] t);
        @(negedge clk);
        rst               = r;
        bus.pc_write_i    = w;
        bus.redirect_i    = d;
        bus.redirect_pc_i = t;
        #1;
    endtask

    task automatic model_step(input bit r, input bit w, input bit d, input logic [15:0] t,
                              input string tag);
        logic [15:0] e_instr, e_pc1;
        bit e_valid;
        drive(r, w, d, t);
        if (m_known) begin
            e_instr = m_bubble ? NOP : mem_word(m_addr);
            e_pc1   = m_bubble ? m_next : m_addr + 16'h1;
            e_valid = !m_bubble;
            check({tag, " instr"}, bus.instr_o, e_instr);
            check({tag, " pc1"},   bus.pc_plus1_o, e_pc1);
            check({tag, " valid"}, {15'h0, bus.instr_valid_o}, {15'h0, e_valid});
            check({tag, " addr"},  bus.imem_addr_o, m_next);
            check({tag, " flush"}, {15'h0, bus.flush_n_o}, {15'h0, !d});
            $display("%s rst=%0d pcw=%0d redir=%0d tgt=%h -> instr=%h pc1=%h v=%0d",
                     tag, r, w, d, t, bus.instr_o, bus.pc_plus1_o, bus.instr_valid_o);
        end
        if (r) begin
            m_known = 1; m_bubble = 1; m_next = 16'h0;
        end else if (d) begin
            m_bubble = 1; m_next = t;
        end else if (w) begin
            m_bubble = 0; m_addr = m_next; m_next = m_next + 16'h1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.pc_write_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = 16'h0;

        //            rst pcw red tgt       chk instr     v  pc1       addr
        tbl[0]  = '{1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[1]  = '{0, 1, 0, 16'h0000, 1, NOP,      0, 16'h0000, 16'h0000};
        tbl[2]  = '{0, 1, 0, 16'h0000, 1, 16'h1000, 1, 16'h0001, 16'h0001};
        tbl[3]  = '{0, 1, 0, 16'h0000, 1, 16'h1001, 1, 16'h0002, 16'h0002};
        tbl[4]  = '{0, 1, 0, 16'h0000, 1, 16'h1002, 1, 16'h0003, 16'h0003};
        tbl[5]  = '{0, 1, 0, 16'h0000, 1, 16'h1003, 1, 16'h0004, 16'h0004};
        tbl[6]  = '{0, 1, 0, 16'h0000, 1, 16'h1004, 1, 16'h0005, 16'h0005};
        tbl[7]  = '{0, 0, 0, 16'h0000, 1, 16'h1005, 1, 16'h0006, 16'h0006};
        tbl[8]  = '{0, 0, 0, 16'h0000, 1, 16'h1005, 1, 16'h0006, 16'h0006};
        tbl[9]  = '{0, 0, 0, 16'h0000, 1, 16'h1005, 1, 16'h0006, 16'h0006};
        tbl[10] = '{0, 1, 0, 16'h0000, 1, 16'h1005, 1, 16'h0006, 16'h0006};
        tbl[11] = '{0, 1, 0, 16'h0000, 1, 16'h1006, 1, 16'h0007, 16'h0007};
        tbl[12] = '{0, 1, 1, 16'h0040, 1, 16'h1007, 1, 16'h0008, 16'h0008};
        tbl[13] = '{0, 1, 0, 16'h0000, 1, NOP,      0, 16'h0040, 16'h0040};
        tbl[14] = '{0, 1, 0, 16'h0000, 1, 16'h1040, 1, 16'h0041, 16'h0041};
        tbl[15] = '{0, 1, 0, 16'h0000, 1, 16'h1041, 1, 16'h0042, 16'h0042};
        tbl[16] = '{0, 0, 0, 16'h0000, 1, 16'h1042, 1, 16'h0043, 16'h0043};
        tbl[17] = '{0, 0, 1, 16'h0080, 1, 16'h1042, 1, 16'h0043, 16'h0043};
        tbl[18] = '{0, 1, 0, 16'h0000, 1, NOP,      0, 16'h0080, 16'h0080};
        tbl[19] = '{0, 1, 0, 16'h0000, 1, 16'h1080, 1, 16'h0081, 16'h0081};
        tbl[20] = '{0, 1, 1, 16'hFFFF, 1, 16'h1081, 1, 16'h0082, 16'h0082};
        tbl[21] = '{0, 1, 0, 16'h0000, 1, NOP,      0, 16'hFFFF, 16'hFFFF};
        tbl[22] = '{0, 1, 0, 16'h0000, 1, 16'h1FFF, 1, 16'h0000, 16'h0000};
        tbl[23] = '{0, 1, 0, 16'h0000, 1, 16'h1000, 1, 16'h0001, 16'h0001};
        tbl[24] = '{0, 0, 0, 16'h0000, 1, 16'h1001, 1, 16'h0002, 16'h0002};
        tbl[25] = '{1, 0, 0, 16'h0000, 1, 16'h1001, 1, 16'h0002, 16'h0002};
        tbl[26] = '{0, 0, 0, 16'h0000, 1, NOP,      0, 16'h0000, 16'h0000};
        tbl[27] = '{0, 0, 0, 16'h0000, 1, NOP,      0, 16'h0000, 16'h0000};
        tbl[28] = '{0, 1, 0, 16'h0000, 1, NOP,      0, 16'h0000, 16'h0000};
        tbl[29] = '{0, 1, 0, 16'h0000, 1, 16'h1000, 1, 16'h0001, 16'h0001};

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst, tbl[i].pcw, tbl[i].redir, tbl[i].tgt);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d instr", i), bus.instr_o, tbl[i].instr);
                check($sformatf("vec%0d pc1", i), bus.pc_plus1_o, tbl[i].pc1);
                check($sformatf("vec%0d valid", i), {15'h0, bus.instr_valid_o}, {15'h0, tbl[i].valid});
                check($sformatf("vec%0d addr", i), bus.imem_addr_o, tbl[i].addr);
                check($sformatf("vec%0d flush", i), {15'h0, bus.flush_n_o}, {15'h0, !tbl[i].redir});
            end
            $display("vec%0d rst=%0d pcw=%0d redir=%0d -> instr=%h pc1=%h v=%0d addr=%h",
                     i, tbl[i].rst, tbl[i].pcw, tbl[i].redir, bus.instr_o,
                     bus.pc_plus1_o, bus.instr_valid_o, bus.imem_addr_o);
        end

        // Hand sequences: reset beats redirect; redirect from a stalled bubble; stall over wrap.
        model_step(1, 1, 1, 16'h1234, "hand0");
        model_step(0, 1, 0, 16'h0000, "hand1");
        model_step(0, 1, 0, 16'h0000, "hand2");
        model_step(0, 0, 1, 16'hFFFE, "hand3");
        model_step(0, 0, 0, 16'h0000, "hand4");
        model_step(0, 0, 1, 16'hFFFF, "hand5");
        model_step(0, 1, 0, 16'h0000, "hand6");
        model_step(0, 0, 0, 16'h0000, "hand7");
        model_step(0, 0, 0, 16'h0000, "hand8");
        model_step(0, 1, 0, 16'h0000, "hand9");
        model_step(0, 1, 0, 16'h0000, "hand10");

        for (int i = 0; i < 500; i++) begin
            bit r, w, d;
            logic [15:0] t;
            r = ($urandom_range(0, 99) < 2);
            w = ($urandom_range(0, 99) < 65);
            d = ($urandom_range(0, 99) < 10);
            t = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                            : 16'($urandom);
            model_step(r, w, d, t, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
